// File: rtl/button_conditioner.sv
// N-channel button conditioner: 2-flop synchroniser, debounce, press/release edges,
// long-press detection and optional auto-repeat, all outputs registered.
module button_conditioner #(
    parameter int             N               = 6,
    parameter int             DEBOUNCE_CYCLES = 1000000,
    parameter int             LONG_CYCLES     = 50000000,
    parameter int             REPEAT_CYCLES   = 10000000,
    parameter int             REPEAT_EN       = 1,
    parameter logic [N-1:0]   INVERT          = {N{1'b0}}
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] btn_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_o,
    output logic [N-1:0] repeat_o
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] L_TERM = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] R_TERM = HW'(REPEAT_CYCLES);
    localparam logic          REP_ON = (REPEAT_EN != 0);

    // ST_HOLD is the silent post-long state used when auto-repeat is disabled.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LONG = 2'd1,
        ST_REPEAT    = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    // Two-flop synchroniser; reset value 0 means "released" after inversion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= {N{1'b0}};
            s2_q <= {N{1'b0}};
        end else begin
            s1_q <= btn_i ^ INVERT;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [DW-1:0] dcnt_q;
        logic [DW-1:0] dcnt_d;
        logic          btn_q;
        logic          btn_d;
        logic          press_ev_s;
        logic          release_ev_s;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          repeat_q;
        logic [HW-1:0] hcnt_q;
        state_t        state_q;

        // Debounce next-state: accept s2 after DEBOUNCE_CYCLES disagreeing samples.
        always_comb begin
            dcnt_d = dcnt_q;
            btn_d  = btn_q;
            if (s2_q[i] == btn_q) begin
                dcnt_d = {DW{1'b0}};
            end else if (dcnt_q == D_TERM) begin
                btn_d  = s2_q[i];
                dcnt_d = {DW{1'b0}};
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
            press_ev_s   = btn_d & ~btn_q;
            release_ev_s = ~btn_d & btn_q;
        end

        // Debounce registers, edge pulses and hold FSM; release overrides any terminal count.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dcnt_q    <= {DW{1'b0}};
                btn_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                hcnt_q    <= {HW{1'b0}};
                state_q   <= ST_IDLE;
            end else begin
                dcnt_q    <= dcnt_d;
                btn_q     <= btn_d;
                press_q   <= press_ev_s;
                release_q <= release_ev_s;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                if (release_ev_s) begin
                    state_q <= ST_IDLE;
                    hcnt_q  <= {HW{1'b0}};
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (press_ev_s) begin
                                state_q <= ST_WAIT_LONG;
                                hcnt_q  <= HW'(1);
                            end else begin
                                hcnt_q  <= {HW{1'b0}};
                            end
                        end
                        ST_WAIT_LONG: begin
                            if (hcnt_q == L_TERM) begin
                                long_q  <= 1'b1;
                                hcnt_q  <= REP_ON ? HW'(1) : {HW{1'b0}};
                                state_q <= REP_ON ? ST_REPEAT : ST_HOLD;
                            end else begin
                                hcnt_q  <= hcnt_q + HW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt_q == R_TERM) begin
                                repeat_q <= 1'b1;
                                hcnt_q   <= HW'(1);
                            end else begin
                                hcnt_q   <= hcnt_q + HW'(1);
                            end
                        end
                        ST_HOLD: begin
                            hcnt_q <= {HW{1'b0}};
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            hcnt_q  <= {HW{1'b0}};
                        end
                    endcase
                end
            end
        end

        assign btn_o[i]     = btn_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
        assign long_o[i]    = long_q;
        assign repeat_o[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a cycle-level
// behavioural model (disagreement streaks and time-since-press arithmetic).
module tb_button_conditioner;

    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int LC  = 20;
    localparam int RC  = 5;
    localparam logic [1:0] INV = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_i;
    logic [1:0] btn_o, press_o, release_o, long_o, repeat_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    bit         m_s1 [N];
    bit         m_s2 [N];
    bit         m_lvl [N];
    int         m_last_agree [N];
    bit         m_held [N];
    int         m_press_at [N];
    logic [1:0] e_btn, e_press, e_rel, e_long, e_rep;

    button_conditioner #(
        .N(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LC),
        .REPEAT_CYCLES(RC), .REPEAT_EN(1), .INVERT(INV)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_i), .btn_o(btn_o),
        .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .repeat_o(repeat_o)
    );

    always #5 clk = ~clk;

    // Advance model by one edge using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit rise, fall;
        int d;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0;
                m_held[i] = 1'b0; m_last_agree[i] = cyc;
                e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0; e_rep[i] = 1'b0;
            end else begin
                rise = 1'b0; fall = 1'b0;
                if (m_s2[i] == m_lvl[i]) begin
                    m_last_agree[i] = cyc;
                end else if (cyc - m_last_agree[i] == DEB) begin
                    m_lvl[i] = m_s2[i];
                    m_last_agree[i] = cyc;
                    rise = m_s2[i];
                    fall = !m_s2[i];
                end
                e_press[i] = rise; e_rel[i] = fall;
                e_long[i] = 1'b0; e_rep[i] = 1'b0;
                if (fall) begin
                    m_held[i] = 1'b0;
                end else if (m_held[i]) begin
                    d = cyc - m_press_at[i];
                    if (d == LC) e_long[i] = 1'b1;
                    else if (d > LC && ((d - LC) % RC) == 0) e_rep[i] = 1'b1;
                end
                if (rise) begin
                    m_held[i] = 1'b1;
                    m_press_at[i] = cyc;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_i[i] ^ INV[i];
            end
            e_btn[i] = m_lvl[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_i = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++;
        if ({btn_o, press_o, release_o, long_o, repeat_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_state got=%b exp=%b", {btn_o, press_o, release_o, long_o, repeat_o}, 10'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_clean_press();
        btn_i[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++;
            if (press_o[0] !== (k == 6) || btn_o[0] !== (k >= 6)) begin
                n_bad++;
                $display("FAIL clean_press k=%0d got press=%b btn=%b exp press=%b btn=%b",
                         k, press_o[0], btn_o[0], (k == 6), (k >= 6));
            end
        end
        btn_i[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if ({btn_o, press_o, release_o, long_o, repeat_o} !== {e_btn, e_press, e_rel, e_long, e_rep}) begin
                n_bad++;
                $display("FAIL release_early cyc=%0d got=%b exp=%b", cyc,
                         {btn_o, press_o, release_o, long_o, repeat_o}, {e_btn, e_press, e_rel, e_long, e_rep});
            end
        end
    endtask

    task automatic test_glitch();
        btn_i[0] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) btn_i[0] = 1'b0;
            tick();
            n_cmp++;
            if (btn_o[0] !== 1'b0 || press_o[0] !== 1'b0 || long_o[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch k=%0d got btn=%b press=%b long=%b exp all 0",
                         k, btn_o[0], press_o[0], long_o[0]);
            end
        end
    endtask

    task automatic test_long_repeat();
        int p;
        bit seen;
        int d;
        seen = 1'b0;
        p = 0;
        btn_i[0] = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (press_o[0] === 1'b1) begin seen = 1'b1; p = cyc; end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL long_press_timeout got=no press exp=press within 20 cycles");
        end
        for (int k = 0; k < 60; k++) begin
            tick();
            d = cyc - p;
            n_cmp++;
            if (long_o[0] !== (d == LC) || repeat_o[0] !== (d > LC && ((d - LC) % RC) == 0)) begin
                n_bad++;
                $display("FAIL long_repeat d=%0d got long=%b rep=%b exp long=%b rep=%b", d,
                         long_o[0], repeat_o[0], (d == LC), (d > LC && ((d - LC) % RC) == 0));
            end
        end
        btn_i[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if ({btn_o, press_o, release_o, long_o, repeat_o} !== {e_btn, e_press, e_rel, e_long, e_rep}) begin
                n_bad++;
                $display("FAIL long_release cyc=%0d got=%b exp=%b", cyc,
                         {btn_o, press_o, release_o, long_o, repeat_o}, {e_btn, e_press, e_rel, e_long, e_rep});
            end
        end
    endtask

    task automatic test_release_on_tc();
        int p;
        p = -1;
        btn_i[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (press_o[0] === 1'b1) p = cyc;
            if (p >= 0 && cyc == p + 14) btn_i[0] = 1'b0;
            if (p >= 0 && cyc == p + 20) begin
                n_cmp++;
                if (release_o[0] !== 1'b1 || long_o[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL release_on_tc got rel=%b long=%b exp rel=1 long=0", release_o[0], long_o[0]);
                end
            end
        end
        n_cmp++;
        if (p < 0 || long_o[0] !== 1'b0 || btn_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL release_on_tc_end got p=%0d long=%b btn=%b exp press seen, long=0 btn=0",
                     p, long_o[0], btn_o[0]);
        end
    endtask

    task automatic test_inverted();
        int rise_at;
        rise_at = -1;
        btn_i[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_o[1] === 1'b1 && rise_at < 0) rise_at = k;
            n_cmp++;
            if (btn_o[0] !== 1'b0 || press_o[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL inverted_ch0 k=%0d got btn0=%b press0=%b exp 0", k, btn_o[0], press_o[0]);
            end
        end
        n_cmp++;
        if (rise_at !== 6) begin
            n_bad++;
            $display("FAIL inverted_rise got=%0d exp=6", rise_at);
        end
        btn_i[1] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_back_to_back();
        btn_i = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (press_o !== ((k == 6) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL simultaneous_press k=%0d got=%b exp=%b", k, press_o, (k == 6) ? 2'b11 : 2'b00);
            end
        end
        btn_i = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (release_o !== ((k == 6) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL simultaneous_release k=%0d got=%b exp=%b", k, release_o, (k == 6) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_reset_held();
        int got;
        got = -1;
        btn_i[0] = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({btn_o, press_o, release_o, long_o, repeat_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_mid got=%b exp=%b", {btn_o, press_o, release_o, long_o, repeat_o}, 10'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (press_o[0] === 1'b1 && got < 0) got = k;
        end
        n_cmp++;
        if (got !== DEB + 2) begin
            n_bad++;
            $display("FAIL reset_held_press got=%0d exp=%0d", got, DEB + 2);
        end
        btn_i[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_random();
        int run [N];
        for (int i = 0; i < N; i++) run[i] = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (run[i] == 0) begin
                    btn_i[i] = $urandom_range(0, 1);
                    run[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 60) : $urandom_range(1, 8);
                end
                run[i]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++;
            if ({btn_o, press_o, release_o, long_o, repeat_o} !== {e_btn, e_press, e_rel, e_long, e_rep}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                         {btn_o, press_o, release_o, long_o, repeat_o}, {e_btn, e_press, e_rel, e_long, e_rep});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn_i = 2'b10;
        #2;
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_repeat();
        test_release_on_tc();
        test_inverted();
        test_back_to_back();
        test_reset_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised successor to the single-channel button debouncer.
- Handles N buttons, each with:
  - a 2-flop synchroniser and polarity inversion;
  - a debounced level output;
  - one-cycle press and release pulses;
  - a long-press pulse and an optional auto-repeat pulse train.
- Sits between board pins (BTNx, CPU_RESETN) and the logic and clap controllers, replacing the per-button debouncer instances.

Parameters:
- N, 6, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive disagreeing cycles needed to accept a new level (10 ms at 100 MHz); must be >= 1.
- LONG_CYCLES, 50000000, cycles after the press pulse at which long_o fires (0.5 s); must be >= 1.
- REPEAT_CYCLES, 10000000, period of repeat_o after long_o (0.1 s); must be >= 1.
- REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = repeat_o tied 0.
- INVERT, {N{1'b0}}, per-channel mask; 1 = pin is active-low (e.g. CPU_RESETN).

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_i  in  1  synchronous reset, active-high.
- btn_i  in  N  raw asynchronous button pins.
- btn_o  out  N  debounced level; 1 = pressed, after INVERT.
- press_o  out  N  1-cycle pulse when btn_o rises.
- release_o  out  N  1-cycle pulse when btn_o falls.
- long_o  out  N  1-cycle pulse, LONG_CYCLES after press_o while still held.
- repeat_o  out  N  1-cycle pulses every REPEAT_CYCLES after long_o while held.

Behaviour:

Reset:
- On the rst_i edge, all synchroniser flops, counters and outputs go to 0 and all channels go to IDLE.
- Synchroniser reset value is the post-inversion 0, i.e. "released".

Synchroniser:
- s1 <= btn_i ^ INVERT, then s2 <= s1.
- Purely 2-flop; no logic between the flops.

Debounce (per channel):
- Counter dcnt has width $clog2(DEBOUNCE_CYCLES+1).
- If s2 == btn_o: dcnt <= 0.
- Else if dcnt == DEBOUNCE_CYCLES-1: btn_o <= s2 and dcnt <= 0.
- Else: dcnt <= dcnt+1.
- Net latency: a clean input change first sampled by s1 at edge k updates btn_o at edge k+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes btn_o.

Edge pulses:
- press_o and release_o are registered and asserted in the same cycle btn_o first shows its new value.
- Each is high for exactly 1 cycle.

Hold FSM (per channel), states IDLE, WAIT_LONG, REPEAT:
- Counter hcnt has width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
- IDLE:
  - On a press event (the edge that sets btn_o=1): go to WAIT_LONG, hcnt <= 1.
- WAIT_LONG:
  - Each cycle, hcnt <= hcnt+1.
  - When hcnt == LONG_CYCLES: long_o = 1 for that cycle, hcnt <= 1, go to REPEAT.
  - With REPEAT_EN=0, go to IDLE-hold instead: stay silent until release.
- REPEAT:
  - When hcnt == REPEAT_CYCLES: repeat_o = 1, hcnt <= 1.
  - Otherwise hcnt <= hcnt+1.
- Timing relative to press_o cycle P:
  - long_o at P+LONG_CYCLES;
  - repeat_o at P+LONG_CYCLES+m*REPEAT_CYCLES, for m >= 1.
- A release event in any state returns the channel to IDLE with hcnt <= 0.
  - release_o pulses.
  - long_o and repeat_o are 0 in the release cycle and afterwards.
  - If release coincides with the long/repeat terminal count, release wins and no long/repeat pulse is emitted.

Channel independence:
- Channels are fully independent.
- Simultaneous events on different channels are each reported in their own bit in the same cycle.

Counter saturation:
- No counter wraps; each is cleared at its terminal value.

Reset mid-operation:
- State is lost.
- If a button is still held when rst_i drops, it is treated as a fresh press: btn_o and press_o rise DEBOUNCE_CYCLES+2 cycles after reset deassertion.

Test Plan:
Bench parameters: N=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, REPEAT_EN=1, INVERT=2'b10.
1. Clean press: btn_i[0] 0->1, sampled at edge 0 -> btn_o[0]=1 and press_o[0]=1 at edge 5 only.
2. Glitch: btn_i[0] high for 3 cycles then low -> btn_o[0], press_o[0], long_o[0] stay 0 throughout.
3. Long hold with repeat: btn_i[0] held 60 cycles -> long_o[0] at P+20, repeat_o[0] at P+25, P+30, P+35 ...
4. Release before long: btn_i[0] released before P+20 -> release_o[0] 1 cycle, no long_o or repeat_o.
5. Release on terminal count: btn_o falls exactly at P+20 -> release_o=1, long_o=0 in that cycle.
6. Inverted channel: btn_i[1] held 1 through reset, then driven 0 -> btn_o[1] rises 6 cycles after btn_i[1] falls; channel 0 unaffected.
7. Reset with held button: rst_i asserted while channel 0 is in REPEAT -> all outputs 0 next cycle; after deassert with button still held, press_o[0] fires 6 cycles later.
